// File: rtl/mm_pkg.sv
// Shared definitions for the matmul BRAM loader slice.
// Holds the FSM state encoding, the nominal beat width and the
// all-bytes write-enable pattern used on both BRAM port A interfaces.
package mm_pkg;

    localparam int BEAT_W = 64;

    localparam logic [7:0] WE_ALL = 8'hFF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_LOAD_I = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

endpackage

// File: rtl/mm_lane_packer.sv
// Packs NUM_CORES consecutive input beats into one wide input BRAM word.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   clear       : drops any partially packed word (new job)
//   beat_valid  : an input beat is accepted this cycle
//   lane        : lane the current beat belongs to (0 first)
//   addr        : input word address the current beat contributes to
//   beat        : beat payload
//   word_valid  : current beat completes a word (combinational pulse)
//   word        : complete word, current beat already inserted
//   word_addr   : address of the completed word
import mm_pkg::*;

module mm_lane_packer #(
    parameter int BW        = BEAT_W,
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 2,
    parameter int LANE_W    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    beat_valid,
    input  logic [LANE_W-1:0]       lane,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [BW-1:0]           beat,
    output logic                    word_valid,
    output logic [BW*NUM_CORES-1:0] word,
    output logic [ADDR_W-1:0]       word_addr
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_CORES - 1);

    logic [BW*NUM_CORES-1:0] pack;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pack <= '0;
        end else if (beat_valid) begin
            pack[int'(lane)*BW +: BW] <= beat;
        end
    end

    // The final lane is merged combinationally so the word can be
    // registered by the top in the same cycle the last beat is accepted.
    always_comb begin
        word                      = pack;
        word[int'(lane)*BW +: BW] = beat;
        word_valid                = beat_valid && (lane == LANE_LAST);
        word_addr                 = addr;
    end

endmodule

// File: rtl/mm_bram_loader.sv
// Write-side loader for the matmul top: consumes a valid/ready beat stream,
// writes W_WORDS weight beats to the weight BRAM, then packs
// I_WORDS*NUM_CORES input beats into the input BRAM, then requests compute
// via start until mm_done.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   go                                  : job request, honoured only in IDLE
//   s_valid/s_data/s_last/s_ready       : beat stream
//   wb_ena/wb_wea/wb_addra/wb_dina      : weight BRAM port A
//   in_ena/in_wea/in_addra/in_dina      : input BRAM port A
//   start/mm_done                       : compute handshake with matmul top
//   busy, job_done, err                 : status
import mm_pkg::*;

module mm_bram_loader #(
    parameter int WIDTH        = 16,
    parameter int CHUNK_SIZE   = 4,
    parameter int NUM_CORES    = 2,
    parameter int W_WORDS      = 6,
    parameter int I_WORDS      = 3,
    parameter int ADDR_WIDTH_W = 3,
    parameter int ADDR_WIDTH_I = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   go,
    input  logic                                   s_valid,
    input  logic [WIDTH*CHUNK_SIZE-1:0]            s_data,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic                                   wb_ena,
    output logic [7:0]                             wb_wea,
    output logic [ADDR_WIDTH_W-1:0]                wb_addra,
    output logic [WIDTH*CHUNK_SIZE-1:0]            wb_dina,
    output logic                                   in_ena,
    output logic [7:0]                             in_wea,
    output logic [ADDR_WIDTH_I-1:0]                in_addra,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  in_dina,
    output logic                                   start,
    input  logic                                   mm_done,
    output logic                                   busy,
    output logic                                   job_done,
    output logic                                   err
);

    localparam int BW     = WIDTH * CHUNK_SIZE;
    localparam int LANE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [ADDR_WIDTH_W-1:0] W_LAST    = ADDR_WIDTH_W'(W_WORDS - 1);
    localparam logic [ADDR_WIDTH_I-1:0] I_LAST    = ADDR_WIDTH_I'(I_WORDS - 1);
    localparam logic [LANE_W-1:0]       LANE_LAST = LANE_W'(NUM_CORES - 1);

    logic [2:0]              state;
    logic [ADDR_WIDTH_W-1:0] w_cnt;
    logic [ADDR_WIDTH_I-1:0] i_cnt;
    logic [LANE_W-1:0]       lane;

    logic                    accept;
    logic                    final_beat;
    logic                    frame_err;
    logic                    job_clear;
    logic                    pk_valid;
    logic [BW*NUM_CORES-1:0] pk_word;
    logic [ADDR_WIDTH_I-1:0] pk_addr;

    assign s_ready    = (state == ST_LOAD_W) || (state == ST_LOAD_I);
    assign busy       = (state != ST_IDLE);
    assign accept     = s_valid && s_ready;
    assign job_clear  = (state == ST_IDLE) && go;

    // Only the last lane of the last input word may carry s_last; any
    // other placement, or its absence there, is a framing error.
    assign final_beat = (state == ST_LOAD_I) && (i_cnt == I_LAST) && (lane == LANE_LAST);
    assign frame_err  = accept && (s_last != final_beat);

    mm_lane_packer #(
        .BW        (BW),
        .NUM_CORES (NUM_CORES),
        .ADDR_W    (ADDR_WIDTH_I),
        .LANE_W    (LANE_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (job_clear),
        .beat_valid (accept && (state == ST_LOAD_I)),
        .lane       (lane),
        .addr       (i_cnt),
        .beat       (s_data),
        .word_valid (pk_valid),
        .word       (pk_word),
        .word_addr  (pk_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            w_cnt    <= '0;
            i_cnt    <= '0;
            lane     <= '0;
            wb_ena   <= 1'b0;
            wb_wea   <= '0;
            wb_addra <= '0;
            wb_dina  <= '0;
            in_ena   <= 1'b0;
            in_wea   <= '0;
            in_addra <= '0;
            in_dina  <= '0;
            start    <= 1'b0;
            job_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            wb_ena   <= 1'b0;
            wb_wea   <= '0;
            in_ena   <= 1'b0;
            in_wea   <= '0;
            job_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        err   <= 1'b0;
                        w_cnt <= '0;
                        i_cnt <= '0;
                        lane  <= '0;
                        state <= ST_LOAD_W;
                    end
                end

                ST_LOAD_W: begin
                    if (accept) begin
                        wb_ena   <= 1'b1;
                        wb_wea   <= WE_ALL;
                        wb_addra <= w_cnt;
                        wb_dina  <= s_data;
                        // Counter saturates so the address never exceeds W_WORDS-1.
                        if (w_cnt != W_LAST) begin
                            w_cnt <= w_cnt + ADDR_WIDTH_W'(1);
                        end
                        if (frame_err) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else if (w_cnt == W_LAST) begin
                            state <= ST_LOAD_I;
                        end
                    end
                end

                ST_LOAD_I: begin
                    if (accept) begin
                        if (pk_valid) begin
                            in_ena   <= 1'b1;
                            in_wea   <= WE_ALL;
                            in_addra <= pk_addr;
                            in_dina  <= pk_word;
                            if (i_cnt != I_LAST) begin
                                i_cnt <= i_cnt + ADDR_WIDTH_I'(1);
                            end
                        end
                        lane <= (lane == LANE_LAST) ? '0 : lane + LANE_W'(1);
                        if (frame_err) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else if (final_beat) begin
                            state <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    start <= 1'b1;
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    if (mm_done) begin
                        start    <= 1'b0;
                        job_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_bram_loader.sv
// Directed bench for mm_bram_loader: clean jobs, stalled jobs, framing
// error recovery, long RUN phase, mid-job reset and go corner cases.
module tb_mm_bram_loader;

    logic          clk;
    logic          rst_n;
    logic          go;
    logic          s_valid;
    logic [63:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic          wb_ena;
    logic [7:0]    wb_wea;
    logic [2:0]    wb_addra;
    logic [63:0]   wb_dina;
    logic          in_ena;
    logic [7:0]    in_wea;
    logic [1:0]    in_addra;
    logic [127:0]  in_dina;
    logic          start;
    logic          mm_done;
    logic          busy;
    logic          job_done;
    logic          err;

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;

    logic [63:0]   wmem [0:7];
    logic [127:0]  imem [0:3];
    int unsigned   wcnt;
    int unsigned   icnt;
    int unsigned   stray;
    logic [2:0]    first_waddr;
    logic          acc_q;

    mm_bram_loader #(
        .WIDTH        (16),
        .CHUNK_SIZE   (4),
        .NUM_CORES    (2),
        .W_WORDS      (6),
        .I_WORDS      (3),
        .ADDR_WIDTH_W (3),
        .ADDR_WIDTH_I (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .wb_ena   (wb_ena),
        .wb_wea   (wb_wea),
        .wb_addra (wb_addra),
        .wb_dina  (wb_dina),
        .in_ena   (in_ena),
        .in_wea   (in_wea),
        .in_addra (in_addra),
        .in_dina  (in_dina),
        .start    (start),
        .mm_done  (mm_done),
        .busy     (busy),
        .job_done (job_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side record of beats taken at each edge.
    always @(posedge clk) acc_q <= s_valid && s_ready && rst_n;

    // Write log: every strobe must follow an accept and carry a full byte enable.
    always @(negedge clk) begin
        if (wb_ena) begin
            if (wcnt == 0) first_waddr = wb_addra;
            wmem[wb_addra] = wb_dina;
            wcnt++;
            if (!acc_q || wb_wea != 8'hFF) stray++;
        end
        if (in_ena) begin
            imem[in_addra] = in_dina;
            icnt++;
            if (!acc_q || in_wea != 8'hFF) stray++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 8; i++) wmem[i] = '0;
        for (int i = 0; i < 4; i++) imem[i] = '0;
        wcnt        = 0;
        icnt        = 0;
        stray       = 0;
        first_waddr = 3'd7;
    endtask

    task automatic check_job(input string t);
        logic [63:0] hi;
        logic [63:0] lo;
        for (int i = 0; i < 6; i++) chk({t, "_wmem"}, 128'(wmem[i]), 128'(i + 1));
        for (int i = 0; i < 3; i++) begin
            hi = 64'(2 * i + 8);
            lo = 64'(2 * i + 7);
            chk({t, "_imem"}, imem[i], {hi, lo});
        end
        chk({t, "_wcnt"}, 128'(wcnt), 128'(6));
        chk({t, "_icnt"}, 128'(icnt), 128'(3));
        chk({t, "_stray"}, 128'(stray), 128'(0));
        chk({t, "_first_waddr"}, 128'(first_waddr), 128'(0));
    endtask

    // Full 12-beat job up to the first RUN cycle.
    task automatic run_job(input string t, input bit gaps, input bit go_in_loadi, input bit early);
        clear_log();
        go = 1'b1;
        if (early) begin
            s_valid = 1'b1;
            s_data  = 64'd1;
            s_last  = 1'b0;
            chk({t, "_idle_ready"}, 128'(s_ready), 128'(0));
        end
        tick();
        go = 1'b0;
        chk({t, "_busy"}, 128'(busy), 128'(1));
        chk({t, "_err_clr"}, 128'(err), 128'(0));
        if (early) chk({t, "_no_early_write"}, 128'(wb_ena), 128'(0));
        for (int k = 1; k <= 12; k++) begin
            s_valid = 1'b1;
            s_data  = 64'(k);
            s_last  = (k == 12);
            if (go_in_loadi && k == 9) go = 1'b1;
            tick();
            go = 1'b0;
            if (early && k == 1) begin
                chk({t, "_early_ena"}, 128'(wb_ena), 128'(1));
                chk({t, "_early_addr"}, 128'(wb_addra), 128'(0));
            end
            if (gaps && k < 12) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk({t, "_settle_start"}, 128'(start), 128'(0));
        chk({t, "_settle_busy"}, 128'(busy), 128'(1));
        tick();
        chk({t, "_run_start"}, 128'(start), 128'(1));
        chk({t, "_run_ready"}, 128'(s_ready), 128'(0));
        check_job(t);
    endtask

    task automatic finish_job(input string t);
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        chk({t, "_done_start"}, 128'(start), 128'(0));
        chk({t, "_done_pulse"}, 128'(job_done), 128'(1));
        chk({t, "_done_busy"}, 128'(busy), 128'(0));
        chk({t, "_done_err"}, 128'(err), 128'(0));
        tick();
        chk({t, "_pulse_end"}, 128'(job_done), 128'(0));
    endtask

    task automatic check_reset_outputs(input string t);
        chk({t, "_wb"}, 128'({wb_ena, wb_wea, wb_addra, wb_dina}), 128'(0));
        chk({t, "_in_ctl"}, 128'({in_ena, in_wea, in_addra}), 128'(0));
        chk({t, "_in_dina"}, in_dina, 128'(0));
        chk({t, "_status"}, 128'({s_ready, start, busy, job_done, err}), 128'(0));
    endtask

    initial begin
        int unsigned hi_cycles;

        rst_n   = 1'b0;
        go      = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        mm_done = 1'b0;
        clear_log();
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 128'(busy), 128'(0));

        // T1: back-to-back clean job
        run_job("t1", 1'b0, 1'b0, 1'b0);
        tick();
        finish_job("t1");

        // T2: stall on every other cycle
        run_job("t2", 1'b1, 1'b0, 1'b0);
        finish_job("t2");

        // T3: s_last on beat 7 (first input beat)
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            s_valid = 1'b1;
            s_data  = 64'(k);
            s_last  = (k == 7);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t3_err", 128'(err), 128'(1));
        chk("t3_busy", 128'(busy), 128'(0));
        chk("t3_ready", 128'(s_ready), 128'(0));
        tick();
        tick();
        chk("t3_start", 128'(start), 128'(0));
        chk("t3_err_sticky", 128'(err), 128'(1));
        run_job("t3r", 1'b0, 1'b0, 1'b0);
        finish_job("t3r");

        // T4: long RUN phase, go coincident with mm_done is ignored
        run_job("t4", 1'b0, 1'b0, 1'b0);
        hi_cycles = 1;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (start) hi_cycles++;
        end
        chk("t4_start_cycles", 128'(hi_cycles), 128'(50));
        go      = 1'b1;
        mm_done = 1'b1;
        tick();
        go      = 1'b0;
        mm_done = 1'b0;
        chk("t4_done_pulse", 128'(job_done), 128'(1));
        chk("t4_done_busy", 128'(busy), 128'(0));
        tick();
        chk("t4_go_ignored", 128'(busy), 128'(0));
        chk("t4_pulse_end", 128'(job_done), 128'(0));

        // T5: reset after 5 weight beats
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            s_valid = 1'b1;
            s_data  = 64'(k + 100);
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        check_reset_outputs("t5_reset");
        rst_n = 1'b1;
        tick();
        run_job("t5", 1'b0, 1'b0, 1'b0);
        finish_job("t5");

        // T6: go during LOAD_I, then go with a beat already valid in IDLE
        run_job("t6a", 1'b0, 1'b1, 1'b0);
        finish_job("t6a");
        run_job("t6b", 1'b0, 1'b0, 1'b1);
        finish_job("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
